// File: rtl/pong_ball_engine.sv
// pong_ball_engine: Pong ball position/direction engine with serve -> play -> scored sequencing.
// Motion and state change only on the frame tick (y == TICK_Y, x == 0). Paddle hits speed the
// ball up. Each point produces a one-clock score pulse. ball_on is a zero-latency pixel test.
//
// Ports
//   clk, reset          pixel clock; asynchronous active-high reset
//   x, y                current pixel coordinates from the VGA controller
//   pad1_box, pad2_box  right / left paddle {top, bottom, left, right}, 10 bits each
//   ball_on             combinational: current pixel lies inside the ball
//   score1, score2      one-clock pulse: player 1 (right) / player 2 (left) scored
//   ball_x, ball_y      ball left / top edge
//   speed               current speed magnitude (pixels per frame)
//   in_play             high while in PLAY
//
// Build option: define BALL_ROUND_EN for a round ball_on mask (circle inside the box).
// Without it, ball_on is a plain square box test. Motion always uses the square box.
module pong_ball_engine #(
    parameter int unsigned X_MAX         = 639,
    parameter int unsigned Y_MAX         = 479,
    parameter int unsigned TICK_Y        = 481,
    parameter int unsigned BALL_SIZE     = 10,
    parameter int unsigned SPEED_MIN     = 1,
    parameter int unsigned SPEED_MAX     = 6,
    parameter int unsigned HITS_PER_STEP = 4,
    parameter int unsigned SERVE_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [39:0] pad1_box,
    input  logic [39:0] pad2_box,
    output logic        ball_on,
    output logic        score1,
    output logic        score2,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [2:0]  speed,
    output logic        in_play
);
    localparam int unsigned PW = 10;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned SW = 3;
    localparam int unsigned HW = $clog2(HITS_PER_STEP + 1);
    localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [PW-1:0] CENTRE_X = PW'((X_MAX - BALL_SIZE) / 2);
    localparam logic [PW-1:0] CENTRE_Y = PW'((Y_MAX - BALL_SIZE) / 2);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   bx_d, by_d;
    logic            dir_x_q, dir_x_d;   // 1 = moving right
    logic            dir_y_q, dir_y_d;   // 1 = moving down
    logic [SW-1:0]   speed_d;
    logic [HW-1:0]   hit_q, hit_d;
    logic [CW-1:0]   serve_q, serve_d;
    logic            score1_d, score2_d;

    logic            tick;
    logic [AW-1:0]   bx, by, spd, right_edge, bottom_edge, nx, ny, xe, ye;
    logic            exit_right, exit_left, wall_top, wall_bot, hit1, hit2, in_box;

    // Square-box overlap of a ball at (px,py) with a paddle box; 11-bit so edges cannot wrap
    function automatic logic overlaps(input logic [AW-1:0] px, input logic [AW-1:0] py,
                                      input logic [39:0] box);
        logic [AW-1:0] top, bot, lft, rgt;
        top = {1'b0, box[39:30]};
        bot = {1'b0, box[29:20]};
        lft = {1'b0, box[19:10]};
        rgt = {1'b0, box[9:0]};
        return (px <= rgt) && (px + AW'(BALL_SIZE - 1) >= lft) &&
               (py <= bot) && (py + AW'(BALL_SIZE - 1) >= top);
    endfunction

    assign tick        = (y == PW'(TICK_Y)) && (x == '0);
    assign bx          = {1'b0, ball_x};
    assign by          = {1'b0, ball_y};
    assign spd         = AW'(speed);
    assign right_edge  = bx + AW'(BALL_SIZE - 1);
    assign bottom_edge = by + AW'(BALL_SIZE - 1);

    // Scoring is tested against the pre-move position in the current direction
    assign exit_right  = dir_x_q && (right_edge + spd > AW'(X_MAX));
    assign exit_left   = !dir_x_q && (bx < spd);
    assign nx          = dir_x_q ? bx + spd : bx - spd;

    // Walls clamp the ball to the border instead of letting it wrap
    assign wall_top    = !dir_y_q && (by < spd);
    assign wall_bot    = dir_y_q && (bottom_edge + spd > AW'(Y_MAX));
    assign ny          = wall_top ? '0 :
                         wall_bot ? AW'(Y_MAX - BALL_SIZE + 1) :
                         (dir_y_q ? by + spd : by - spd);

    // A paddle only counts when the ball heads toward it, so a lingering overlap is not re-hit
    assign hit1        = dir_x_q && overlaps(nx, ny, pad1_box);
    assign hit2        = !dir_x_q && overlaps(nx, ny, pad2_box);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_SERVE;
            ball_x  <= CENTRE_X;
            ball_y  <= CENTRE_Y;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b0;
            speed   <= SW'(SPEED_MIN);
            hit_q   <= '0;
            serve_q <= '0;
            score1  <= 1'b0;
            score2  <= 1'b0;
            in_play <= 1'b0;
        end else begin
            state_q <= state_d;
            ball_x  <= bx_d;
            ball_y  <= by_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            speed   <= speed_d;
            hit_q   <= hit_d;
            serve_q <= serve_d;
            score1  <= score1_d;
            score2  <= score2_d;
            in_play <= (state_d == S_PLAY);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        bx_d     = ball_x;
        by_d     = ball_y;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        speed_d  = speed;
        hit_d    = hit_q;
        serve_d  = serve_q;
        score1_d = 1'b0;
        score2_d = 1'b0;
        case (state_q)
            S_SERVE: begin
                if (tick) begin
                    if (serve_q == CW'(SERVE_FRAMES - 1)) begin
                        state_d = S_PLAY;
                        serve_d = '0;
                    end else begin
                        serve_d = serve_q + CW'(1);
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (exit_right) begin
                        score2_d = 1'b1;
                        state_d  = S_SCORED;
                    end else if (exit_left) begin
                        score1_d = 1'b1;
                        state_d  = S_SCORED;
                    end else begin
                        bx_d = nx[PW-1:0];
                        by_d = ny[PW-1:0];
                        if (wall_top) dir_y_d = 1'b1;
                        if (wall_bot) dir_y_d = 1'b0;
                        if (hit1)      dir_x_d = 1'b0;
                        else if (hit2) dir_x_d = 1'b1;
                        if (hit1 || hit2) begin
                            if (hit_q == HW'(HITS_PER_STEP - 1)) begin
                                hit_d   = '0;
                                speed_d = (speed >= SW'(SPEED_MAX)) ? SW'(SPEED_MAX)
                                                                    : speed + SW'(1);
                            end else begin
                                hit_d = hit_q + HW'(1);
                            end
                        end
                    end
                end
            end
            S_SCORED: begin
                // Serve toward whoever conceded: player 2 scoring means the right side lost
                state_d = S_SERVE;
                bx_d    = CENTRE_X;
                by_d    = CENTRE_Y;
                speed_d = SW'(SPEED_MIN);
                hit_d   = '0;
                dir_x_d = score2;
            end
            default: state_d = S_SERVE;
        endcase
    end

    // Pixel test against the registered position
    assign xe     = {1'b0, x};
    assign ye     = {1'b0, y};
    assign in_box = (xe >= bx) && (xe <= right_edge) && (ye >= by) && (ye <= bottom_edge);

`ifdef BALL_ROUND_EN
    localparam int unsigned R   = BALL_SIZE / 2;
    localparam int unsigned DW  = AW + 1;
    localparam int unsigned D2W = 2 * DW;
    logic [AW-1:0]         cx, cy;
    logic signed [DW-1:0]  dx, dy;
    logic signed [D2W-1:0] dx2, dy2;

    assign cx      = bx + AW'(R);
    assign cy      = by + AW'(R);
    assign dx      = $signed({1'b0, xe}) - $signed({1'b0, cx});
    assign dy      = $signed({1'b0, ye}) - $signed({1'b0, cy});
    assign dx2     = dx * dx;
    assign dy2     = dy * dy;
    assign ball_on = in_box && ((dx2 + dy2) <= $signed(D2W'(R * R)));
`else
    assign ball_on = in_box;
`endif

endmodule
